// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch stage: owns the PC and a loadable instruction memory, and
// sequences IDLE/RUN/HALT under start, resume, restart, stall and redirect.
module fetch_stage_ctrl #(
  parameter int unsigned        ADDR_W     = 6,
  parameter int unsigned        INSTR_W    = 16,
  parameter logic [4:0]         HLT_OPCODE = 5'b11111,
  parameter logic [INSTR_W-1:0] NOP_WORD   = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               resume,
  input  logic               restart,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               halted,
  output logic               running
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
  logic               valid_q, valid_d;

  logic [INSTR_W-1:0] mem_q [2**ADDR_W];
  logic [INSTR_W-1:0] fetch_word;
  logic               fetch_is_hlt;

  // Memory is never reset; a write lands at the edge so a same-cycle fetch sees the old word.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  assign fetch_word   = mem_q[pc_q];
  assign fetch_is_hlt = (fetch_word[INSTR_W-1 -: 5] == HLT_OPCODE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;

    if (restart) begin
      state_d = S_IDLE;
      pc_d    = '0;
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (redirect) begin
      // A redirect in HALT squashes a speculatively fetched HLT and resumes fetch.
      pc_d    = redirect_pc;
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      if (state_q == S_HALT) begin
        state_d = S_RUN;
      end
    end else if (!stall) begin
      unique case (state_q)
        S_IDLE: begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          if (start) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          instr_d = fetch_word;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDR_W'(1);
          if (fetch_is_hlt) begin
            state_d = S_HALT;
          end
        end
        S_HALT: begin
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          if (resume) begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = S_IDLE;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= NOP_WORD;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  assign if_instruction = instr_q;
  assign if_pc          = ifpc_q;
  assign if_valid       = valid_q;
  assign pc_out         = pc_q;
  assign halted         = (state_q == S_HALT);
  assign running        = (state_q == S_RUN);

endmodule
